// File: rtl/xml_pkg.sv
// Shared types and character constants for the XML tag value extractor.
package xml_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StName,
    StWaitData,
    StCapture,
    StEmit
  } state_e;

  localparam logic [7:0] ChSlash = 8'h2F;
  localparam logic [7:0] ChLt    = 8'h3C;
  localparam logic [7:0] ChGt    = 8'h3E;
  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChTab   = 8'h09;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChLf    = 8'h0A;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == ChSpace) || (c == ChTab) || (c == ChCr) || (c == ChLf);
  endfunction

endpackage

// File: rtl/xml_tag_value_extractor_if.sv
// Annotated decoder byte stream in, captured value record out (valid/ready).
interface xml_tag_value_extractor_if #(
  parameter int unsigned MAX_VALUE = 32,
  parameter int unsigned LEN_W     = 6
);
  logic                   in_valid;
  logic [7:0]             in_char;
  logic                   in_new_msg;
  logic                   in_is_tag;
  logic                   in_is_tag_name;
  logic                   in_is_data;
  logic [3:0]             in_tag_depth;

  logic                   out_valid;
  logic                   out_ready;
  logic [8*MAX_VALUE-1:0] out_data;
  logic [LEN_W-1:0]       out_len;
  logic                   out_truncated;

  modport slave (
    input  in_valid, in_char, in_new_msg, in_is_tag, in_is_tag_name, in_is_data, in_tag_depth,
    input  out_ready,
    output out_valid, out_data, out_len, out_truncated
  );

  modport master (
    output in_valid, in_char, in_new_msg, in_is_tag, in_is_tag_name, in_is_data, in_tag_depth,
    output out_ready,
    input  out_valid, out_data, out_len, out_truncated
  );
endinterface

// File: rtl/xml_name_matcher.sv
// Detects opening-tag name starts at the configured depth and compares the name bytes.
module xml_name_matcher
  import xml_pkg::*;
#(
  parameter int unsigned MAX_NAME = 16,
  parameter int unsigned LEN_W    = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [7:0]            char_i,
  input  logic                  is_tag_name_i,
  input  logic [3:0]            tag_depth_i,
  input  logic [8*MAX_NAME-1:0] cfg_name_i,
  input  logic [LEN_W-1:0]      cfg_name_len_i,
  input  logic [3:0]            cfg_depth_i,
  input  logic                  start_en_i,
  input  logic                  active_i,
  output logic                  name_start_o,
  output logic                  match_o
);

  logic [7:0]       prev_char_q;
  logic             prev_name_q;
  logic [LEN_W-1:0] name_idx_q, name_idx_d;
  logic             name_ok_q, name_ok_d;
  logic [7:0]       name_byte;

  // Closing tags are recognised by the '/' that precedes their first name byte.
  assign name_start_o = valid_i && is_tag_name_i && !prev_name_q && (prev_char_q != ChSlash) &&
                        (tag_depth_i == cfg_depth_i);
  assign match_o      = name_ok_q && (name_idx_q == cfg_name_len_i);

  always_comb begin
    name_byte = '0;
    for (int i = 0; i < int'(MAX_NAME); i++) begin
      if (name_idx_q == LEN_W'(i)) name_byte = cfg_name_i[8*i +: 8];
    end
  end

  always_comb begin
    name_idx_d = name_idx_q;
    name_ok_d  = name_ok_q;
    if (start_en_i && name_start_o) begin
      name_idx_d = LEN_W'(1);
      name_ok_d  = (char_i == cfg_name_i[7:0]);
    end else if (active_i && valid_i && is_tag_name_i) begin
      name_ok_d  = name_ok_q && (name_idx_q < cfg_name_len_i) && (char_i == name_byte);
      name_idx_d = (name_idx_q == LEN_W'(MAX_NAME)) ? name_idx_q : name_idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_char_q <= '0;
      prev_name_q <= 1'b0;
      name_idx_q  <= '0;
      name_ok_q   <= 1'b0;
    end else begin
      if (valid_i) begin
        prev_char_q <= char_i;
        prev_name_q <= is_tag_name_i;
      end
      name_idx_q <= name_idx_d;
      name_ok_q  <= name_ok_d;
    end
  end

endmodule

// File: rtl/xml_tag_value_extractor.sv
// Captures the text following one configured opening tag and emits it as a record.
// Optional leading/trailing whitespace trimming: define XML_EXTRACT_TRIM_EN.
module xml_tag_value_extractor
  import xml_pkg::*;
#(
  parameter int unsigned MAX_NAME  = 16,
  parameter int unsigned MAX_VALUE = 32,
  parameter int unsigned LEN_W     = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  xml_tag_value_extractor_if.slave       bus_io,
  input  logic [8*MAX_NAME-1:0]          cfg_name_i,
  input  logic [LEN_W-1:0]               cfg_name_len_i,
  input  logic [3:0]                     cfg_depth_i,
  output logic [7:0]                     drop_count_o
);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [8*MAX_VALUE-1:0] buf_q, buf_d;
  logic                   trunc_q, trunc_d;
  logic [7:0]             drop_q, drop_d;

  logic v, abort, start_en, name_active, name_start, match, keep_byte;
  logic store, set_trunc, clr, drop_inc;

  assign v = bus_io.in_valid;
  // A new message aborts an unfinished capture; that byte is then judged as idle input.
  assign abort = v && bus_io.in_new_msg &&
                 ((state_q == StName) || (state_q == StWaitData) || (state_q == StCapture));
  assign start_en    = (state_q == StIdle) || abort;
  assign name_active = (state_q == StName) && !abort;

  xml_name_matcher #(
    .MAX_NAME (MAX_NAME),
    .LEN_W    (LEN_W)
  ) u_name_matcher (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (v),
    .char_i         (bus_io.in_char),
    .is_tag_name_i  (bus_io.in_is_tag_name),
    .tag_depth_i    (bus_io.in_tag_depth),
    .cfg_name_i     (cfg_name_i),
    .cfg_name_len_i (cfg_name_len_i),
    .cfg_depth_i    (cfg_depth_i),
    .start_en_i     (start_en),
    .active_i       (name_active),
    .name_start_o   (name_start),
    .match_o        (match)
  );

`ifdef XML_EXTRACT_TRIM_EN
  logic [LEN_W-1:0] trim_len_q, trim_len_d;
  assign keep_byte = !((len_q == '0) && is_ws(bus_io.in_char));
`else
  assign keep_byte = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    store     = 1'b0;
    set_trunc = 1'b0;
    clr       = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (name_start) state_d = StName;
      end
      StName: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = name_start ? StName : StIdle;
        end else if (v && !bus_io.in_is_tag_name) begin
          state_d = match ? StWaitData : StIdle;
        end
      end
      StWaitData: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = name_start ? StName : StIdle;
        end else if (v && bus_io.in_is_tag_name) begin
          state_d = StEmit;
        end else if (v && !bus_io.in_is_tag && bus_io.in_is_data && keep_byte) begin
          store   = 1'b1;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (abort) begin
          clr     = 1'b1;
          state_d = name_start ? StName : StIdle;
        end else if (v && bus_io.in_is_tag) begin
          state_d = StEmit;
        end else if (v && bus_io.in_is_data && keep_byte) begin
          if (len_q < LEN_W'(MAX_VALUE)) store = 1'b1;
          else                           set_trunc = 1'b1;
        end
      end
      StEmit: begin
        drop_inc = name_start;
        if (bus_io.out_ready) begin
          clr     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    buf_d   = buf_q;
    trunc_d = trunc_q;
    drop_d  = drop_q;
`ifdef XML_EXTRACT_TRIM_EN
    trim_len_d = trim_len_q;
`endif
    if (clr) begin
      len_d   = '0;
      buf_d   = '0;
      trunc_d = 1'b0;
`ifdef XML_EXTRACT_TRIM_EN
      trim_len_d = '0;
`endif
    end else begin
      if (store) begin
        for (int i = 0; i < int'(MAX_VALUE); i++) begin
          if (len_q == LEN_W'(i)) buf_d[8*i +: 8] = bus_io.in_char;
        end
        len_d = len_q + LEN_W'(1);
`ifdef XML_EXTRACT_TRIM_EN
        if (!is_ws(bus_io.in_char)) trim_len_d = len_q + LEN_W'(1);
`endif
      end
      if (set_trunc) trunc_d = 1'b1;
    end
    if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q   <= '0;
      buf_q   <= '0;
      trunc_q <= 1'b0;
      drop_q  <= '0;
`ifdef XML_EXTRACT_TRIM_EN
      trim_len_q <= '0;
`endif
    end else begin
      len_q   <= len_d;
      buf_q   <= buf_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
`ifdef XML_EXTRACT_TRIM_EN
      trim_len_q <= trim_len_d;
`endif
    end
  end

  always_comb begin
    bus_io.out_valid     = (state_q == StEmit);
    bus_io.out_truncated = trunc_q;
    drop_count_o         = drop_q;
`ifdef XML_EXTRACT_TRIM_EN
    bus_io.out_len  = trim_len_q;
    bus_io.out_data = '0;
    for (int i = 0; i < int'(MAX_VALUE); i++) begin
      if (LEN_W'(i) < trim_len_q) bus_io.out_data[8*i +: 8] = buf_q[8*i +: 8];
    end
`else
    bus_io.out_len  = len_q;
    bus_io.out_data = buf_q;
`endif
  end

endmodule

// File: tb/tb_xml_tag_value_extractor.sv
// Drives annotated XML streams into a 32-byte and a 4-byte extractor and scoreboards records.
module tb_xml_tag_value_extractor;

  typedef struct {
    logic [255:0] data;
    int           len;
    bit           trunc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] cfg_name;
  logic [5:0]   cfg_len;
  logic [3:0]   cfg_depth;
  logic [7:0]   drop32, drop4;
  logic         rdy;

  int checks = 0;
  int errors = 0;
  rec_t q32[$];
  rec_t q4[$];
  string ws_msg;
  string ws_val;

  // Behavioural stand-in for the upstream scanning decoder.
  bit       dm_in_tag, dm_pend, dm_in_name, dm_closing;
  int       dm_depth;

  always #5 clk = ~clk;

  xml_tag_value_extractor_if #(.MAX_VALUE(32), .LEN_W(6)) bus ();
  xml_tag_value_extractor_if #(.MAX_VALUE(4),  .LEN_W(6)) bus4 ();

  assign bus4.in_valid       = bus.in_valid;
  assign bus4.in_char        = bus.in_char;
  assign bus4.in_new_msg     = bus.in_new_msg;
  assign bus4.in_is_tag      = bus.in_is_tag;
  assign bus4.in_is_tag_name = bus.in_is_tag_name;
  assign bus4.in_is_data     = bus.in_is_data;
  assign bus4.in_tag_depth   = bus.in_tag_depth;
  assign bus4.out_ready      = bus.out_ready;

  xml_tag_value_extractor #(.MAX_NAME(16), .MAX_VALUE(32), .LEN_W(6)) u_dut32 (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus_io         (bus.slave),
    .cfg_name_i     (cfg_name),
    .cfg_name_len_i (cfg_len),
    .cfg_depth_i    (cfg_depth),
    .drop_count_o   (drop32)
  );

  xml_tag_value_extractor #(.MAX_NAME(16), .MAX_VALUE(4), .LEN_W(6)) u_dut4 (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus_io         (bus4.slave),
    .cfg_name_i     (cfg_name),
    .cfg_name_len_i (cfg_len),
    .cfg_depth_i    (cfg_depth),
    .drop_count_o   (drop4)
  );

  function automatic bit tb_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic rec_t mk(input string v, input int maxv);
    rec_t r;
    int   st = 0;
    r.data  = '0;
    r.len   = 0;
    r.trunc = 1'b0;
`ifdef XML_EXTRACT_TRIM_EN
    while (st < v.len() && tb_ws(v[st])) st++;
`endif
    for (int i = st; i < v.len(); i++) begin
      if (r.len < maxv) begin
        r.data[8*r.len +: 8] = v[i];
        r.len++;
      end else begin
        r.trunc = 1'b1;
      end
    end
`ifdef XML_EXTRACT_TRIM_EN
    while (r.len > 0 && tb_ws(r.data[8*(r.len-1) +: 8])) begin
      r.data[8*(r.len-1) +: 8] = 8'h00;
      r.len--;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string v);
    q32.push_back(mk(v, 32));
    q4.push_back(mk(v, 4));
  endtask

  // Scoreboard pop on every handshake; called with inputs already set for the coming edge.
  task automatic mon();
    rec_t e;
    if (bus.out_valid && bus.out_ready) begin
      chk("rec32_expected", 256'(q32.size() != 0), 256'(1));
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("len32", 256'(bus.out_len), 256'(e.len));
        chk("data32", 256'(bus.out_data), e.data);
        chk("trunc32", 256'(bus.out_truncated), 256'(e.trunc));
      end
    end
    if (bus4.out_valid && bus4.out_ready) begin
      chk("rec4_expected", 256'(q4.size() != 0), 256'(1));
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("len4", 256'(bus4.out_len), 256'(e.len));
        chk("data4", 256'(bus4.out_data), e.data);
        chk("trunc4", 256'(bus4.out_truncated), 256'(e.trunc));
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] c, input bit nm, input bit tg, input bit nf,
                     input bit dt, input logic [3:0] dp);
    @(negedge clk);
    bus.in_valid       = v;
    bus.in_char        = c;
    bus.in_new_msg     = nm;
    bus.in_is_tag      = tg;
    bus.in_is_tag_name = nf;
    bus.in_is_data     = dt;
    bus.in_tag_depth   = dp;
    bus.out_ready      = rdy;
    mon();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic put(input logic [7:0] c, input bit nm);
    bit tg = 0, nf = 0, dt = 0;
    logic [3:0] dp;
    if (nm) begin
      dm_in_tag = 0;
      dm_depth  = 0;
    end
    dp = 4'(dm_depth);
    if (!dm_in_tag) begin
      if (c == "<") begin
        dm_in_tag  = 1;
        dm_pend    = 1;
        dm_closing = 0;
        dm_in_name = 0;
        tg         = 1;
      end else begin
        dt = 1;
      end
    end else begin
      tg = 1;
      if (c == ">") begin
        dm_depth   = dm_closing ? dm_depth - 1 : dm_depth + 1;
        dm_in_tag  = 0;
        dm_in_name = 0;
      end else if (c == "/" && dm_pend) begin
        dm_closing = 1;
      end else if ((dm_pend || dm_in_name) && c != " ") begin
        nf         = 1;
        dm_in_name = 1;
        dm_pend    = 0;
      end else if (c == " ") begin
        dm_in_name = 0;
        dm_pend    = 0;
      end
    end
    cyc(1'b1, c, nm, tg, nf, dt, dp);
  endtask

  // Invalid filler cycles carry random garbage that must be ignored.
  task automatic send(input string s, input bit nm);
    for (int i = 0; i < s.len(); i++) begin
      put(s[i], nm && (i == 0));
      if (i % 3 == 2) begin
        cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom));
      end
    end
  endtask

  initial begin
    cfg_name        = '0;
    cfg_name[7:0]   = "p";
    cfg_name[15:8]  = "x";
    cfg_len         = 6'd2;
    cfg_depth       = 4'd1;
    rdy             = 1'b1;
    dm_in_tag = 0; dm_pend = 0; dm_in_name = 0; dm_closing = 0; dm_depth = 0;
    bus.in_valid = 0; bus.in_char = 0; bus.in_new_msg = 0; bus.in_is_tag = 0;
    bus.in_is_tag_name = 0; bus.in_is_data = 0; bus.in_tag_depth = 0; bus.out_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_valid32", 256'(bus.out_valid), 256'(0));
    chk("rst_len32", 256'(bus.out_len), 256'(0));
    chk("rst_data32", 256'(bus.out_data), 256'(0));
    chk("rst_trunc32", 256'(bus.out_truncated), 256'(0));
    chk("rst_drop32", 256'(drop32), 256'(0));
    chk("rst_valid4", 256'(bus4.out_valid), 256'(0));
    chk("rst_data4", 256'(bus4.out_data), 256'(0));
    rst = 1'b0;
    idle(2);

    expect_val("1234");
    send("<m><px>1234</px></m>", 1'b1);
    idle(4);
    chk("q_empty_basic", 256'(q32.size() + q4.size()), 256'(0));

    expect_val("7");
    send("<m><pxy>9</pxy><px>7</px></m>", 1'b1);
    idle(4);
    chk("q_empty_pxy", 256'(q32.size() + q4.size()), 256'(0));

    expect_val("123456");
    send("<m><px>123456</px></m>", 1'b1);
    idle(4);
    chk("q_empty_trunc", 256'(q32.size() + q4.size()), 256'(0));

    ws_val     = "  42 x";
    ws_val[5]  = 8'h0A;
    ws_msg     = "<m><px>  42 x</px></m>";
    ws_msg[12] = 8'h0A;
    expect_val(ws_val);
    send(ws_msg, 1'b1);
    idle(4);
    chk("q_empty_ws", 256'(q32.size() + q4.size()), 256'(0));

    expect_val("8");
    send("<m><px>12", 1'b1);
    send("<m><px>8</px></m>", 1'b1);
    idle(4);
    chk("q_empty_abort", 256'(q32.size() + q4.size()), 256'(0));

    // Back-pressure: the first record is held while a second match is dropped.
    rdy = 1'b0;
    expect_val("5");
    send("<m><px>5</px></m>", 1'b1);
    send("<m><px>5</px></m>", 1'b1);
    idle(3);
    chk("stall_valid", 256'(bus.out_valid), 256'(1));
    chk("stall_len", 256'(bus.out_len), 256'(1));
    chk("stall_data", 256'(bus.out_data), 256'("5"));
    chk("stall_drop32", 256'(drop32), 256'(1));
    chk("stall_drop4", 256'(drop4), 256'(1));
    idle(2);
    chk("stall_hold_data", 256'(bus.out_data), 256'("5"));
    rdy = 1'b1;
    idle(1);
    chk("stall_popped", 256'(q32.size() + q4.size()), 256'(0));
    idle(1);
    chk("post_xfer_valid32", 256'(bus.out_valid), 256'(0));
    chk("post_xfer_valid4", 256'(bus4.out_valid), 256'(0));
    idle(3);
    chk("q_empty_stall", 256'(q32.size() + q4.size()), 256'(0));

    // Asynchronous reset while a record is pending.
    rdy = 1'b0;
    send("<m><px>3</px></m>", 1'b1);
    idle(2);
    chk("pre_rst_valid", 256'(bus.out_valid), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid32", 256'(bus.out_valid), 256'(0));
    chk("async_rst_valid4", 256'(bus4.out_valid), 256'(0));
    chk("async_rst_len", 256'(bus.out_len), 256'(0));
    chk("async_rst_drop", 256'(drop32), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;
    idle(2);

    expect_val("9");
    send("<m><px>9</px></m>", 1'b1);
    idle(4);
    chk("q_empty_final", 256'(q32.size() + q4.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
